// File: rtl/mask_stream_apply.sv
`default_nettype none
// ============================================================================
//  Module      : mask_stream_apply
//  Description : Streaming front-end for the mask ROM. Accepts RGB444 camera
//                pixels in raster order, tracks the (row,col) position of each
//                pixel, drives the combinational mask ROM address and registers
//                the masked pixel for the downstream frame-buffer writer.
//
//  Ports
//    clk        : system clock, all logic on the rising edge
//    rst        : synchronous, active-high reset
//    in_valid   : input pixel valid
//    in_ready   : block can accept an input pixel this cycle
//    in_sof     : in_pixel is the first pixel of a frame (row 0, col 0)
//    in_pixel   : input pixel, {R[11:8], G[7:4], B[3:0]}
//    rom_row    : mask ROM row address
//    rom_col    : mask ROM column address
//    rom_data   : mask ROM colour data, valid in the same cycle as the address
//    blend_sel  : (MASK_BLEND_EN only) 1 = average pixel and mask per channel,
//                 0 = bitwise AND; sampled on accept
//    out_valid  : masked pixel valid
//    out_ready  : downstream accepts the pixel
//    out_pixel  : masked pixel
//    out_eol    : out_pixel is the last pixel of a line
//    out_eof    : out_pixel is the last pixel of a frame
//    sync_err   : sticky, in_sof was seen while the counters were not at (0,0)
//
//  Build option
//    MASK_BLEND_EN : when defined, adds blend_sel and the per-channel
//                    averaging datapath. Undefined builds are AND-only.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mask_stream_apply #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int COL_W = 8,
    parameter int ROW_W = 7,
    parameter int PIX_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic [ROW_W-1:0] rom_row,
    output logic [COL_W-1:0] rom_col,
    input  logic [PIX_W-1:0] rom_data,
`ifdef MASK_BLEND_EN
    input  logic             blend_sel,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_eol,
    output logic             out_eof,
    output logic             sync_err
);

    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] C_COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] C_ROW_ONE  = ROW_W'(1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic             r_out_valid;
    logic [PIX_W-1:0] r_out_pixel;
    logic             r_out_eol;
    logic             r_out_eof;
    logic             r_sync_err;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_accept;
    logic w_transfer;
    logic w_sof;

    // The single output register can be refilled in the same cycle it is
    // drained, which gives full throughput without a skid buffer.
    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_transfer = r_out_valid && out_ready;
    assign w_sof      = in_valid && in_sof;

    // ------------------------------------------------------------------
    // Position of the pixel currently presented. A start-of-frame pixel is
    // always treated as (0,0), regardless of where the counters are.
    // ------------------------------------------------------------------
    logic [ROW_W-1:0] w_cur_row;
    logic [COL_W-1:0] w_cur_col;
    logic             w_col_last;
    logic             w_row_last;
    logic [ROW_W-1:0] w_next_row;
    logic [COL_W-1:0] w_next_col;
    logic             w_at_origin;

    assign w_cur_row   = w_sof ? '0 : r_row;
    assign w_cur_col   = w_sof ? '0 : r_col;
    assign w_col_last  = (w_cur_col == C_COL_LAST);
    assign w_row_last  = (w_cur_row == C_ROW_LAST);
    assign w_at_origin = (r_row == '0) && (r_col == '0);

    // Raster advance: wrap the column at end of line, wrap the frame at the
    // last pixel. Counters therefore never leave the ROM address range.
    always_comb begin
        w_next_row = w_cur_row;
        w_next_col = w_cur_col + C_COL_ONE;
        if (w_col_last) begin
            w_next_col = '0;
            w_next_row = w_row_last ? '0 : (w_cur_row + C_ROW_ONE);
        end
    end

    assign rom_row = w_cur_row;
    assign rom_col = w_cur_col;

    // ------------------------------------------------------------------
    // Masking datapath
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] w_and_pixel;
    logic [PIX_W-1:0] w_masked;

    assign w_and_pixel = in_pixel & rom_data;

`ifdef MASK_BLEND_EN
    localparam int C_NUM_CH = PIX_W / 4;

    logic [PIX_W-1:0] w_blend_pixel;

    // Per-channel average: 5-bit sum keeps the carry, the shift drops the
    // LSB (truncating rather than rounding).
    generate
        for (genvar g_ch = 0; g_ch < C_NUM_CH; g_ch++) begin : g_blend_ch
            logic [4:0] w_sum;
            assign w_sum = {1'b0, in_pixel[g_ch*4 +: 4]} + {1'b0, rom_data[g_ch*4 +: 4]};
            assign w_blend_pixel[g_ch*4 +: 4] = w_sum[4:1];
        end
        if ((PIX_W % 4) != 0) begin : g_blend_rem
            // Bits that do not form a full channel fall back to AND.
            assign w_blend_pixel[PIX_W-1:C_NUM_CH*4] = w_and_pixel[PIX_W-1:C_NUM_CH*4];
        end
    endgenerate

    assign w_masked = blend_sel ? w_blend_pixel : w_and_pixel;
`else
    assign w_masked = w_and_pixel;
`endif

    // ------------------------------------------------------------------
    // Output register, counters and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_sync_err  <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_pixel <= w_masked;
                r_out_eol   <= w_col_last;
                r_out_eof   <= w_col_last && w_row_last;
                r_row       <= w_next_row;
                r_col       <= w_next_col;
                if (w_sof && !w_at_origin) begin
                    r_sync_err <= 1'b1;
                end
            end else if (w_transfer) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;
    assign out_eol   = r_out_eol;
    assign out_eof   = r_out_eof;
    assign sync_err  = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_mask_stream_apply.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mask_stream_apply
//  Description : Self-checking bench for mask_stream_apply. A linear pixel
//                index model (row*IMG_W+col) predicts the ROM address, the
//                handshake and the registered output of every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mask_stream_apply;

    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int NPIX  = IMG_W * IMG_H;
`ifdef MASK_BLEND_EN
    localparam bit HAS_BLEND = 1'b1;
`else
    localparam bit HAS_BLEND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sof = 1'b0;
    logic [11:0] in_pixel = '0;
    logic [6:0]  rom_row;
    logic [7:0]  rom_col;
    logic [11:0] rom_data = '0;
    logic        blend_sel = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_pixel;
    logic        out_eol;
    logic        out_eof;
    logic        sync_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          exp_valid;
    logic [11:0] exp_pixel;
    bit          exp_eol;
    bit          exp_eof;
    bit          exp_err;
    int          pos;

    always #5 clk = ~clk;

    mask_stream_apply dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_pixel  (in_pixel),
        .rom_row   (rom_row),
        .rom_col   (rom_col),
        .rom_data  (rom_data),
`ifdef MASK_BLEND_EN
        .blend_sel (blend_sel),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .sync_err  (sync_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_pix(input logic [11:0] p, input logic [11:0] m, input bit bl);
        logic [11:0] r;
        int a, b;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            a = (p >> (4 * ch)) & 15;
            b = (m >> (4 * ch)) & 15;
            if (bl) r = r | 12'(((a + b) / 2) << (4 * ch));
            else    r = r | 12'((a & b) << (4 * ch));
        end
        return r;
    endfunction

    // One clock: drive at negedge, check combinational outputs, advance the
    // model at the posedge, check registered outputs at the next negedge.
    task automatic step(input bit v, input bit sof, input logic [11:0] pix,
                        input logic [11:0] mask, input bit ordy, input bit bl);
        int eff;
        bit acc, xfer;
        in_valid  = v;
        in_sof    = v && sof;
        in_pixel  = pix;
        rom_data  = mask;
        out_ready = ordy;
        blend_sel = bl;
        #1;
        eff = (v && sof) ? 0 : pos;
        check("in_ready", 32'(in_ready), 32'(!exp_valid || ordy));
        check("rom_row", 32'(rom_row), 32'(eff / IMG_W));
        check("rom_col", 32'(rom_col), 32'(eff % IMG_W));
        acc  = v && (!exp_valid || ordy);
        xfer = exp_valid && ordy;
        @(posedge clk);
        if (acc) begin
            exp_pixel = ref_pix(pix, mask, HAS_BLEND && bl);
            exp_eol   = (eff % IMG_W) == IMG_W - 1;
            exp_eof   = eff == NPIX - 1;
            if (v && sof && pos != 0) exp_err = 1'b1;
            pos       = (eff + 1) % NPIX;
            exp_valid = 1'b1;
        end else if (xfer) begin
            exp_valid = 1'b0;
        end
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("sync_err", 32'(sync_err), 32'(exp_err));
        if (exp_valid) begin
            check("out_pixel", 32'(out_pixel), 32'(exp_pixel));
            check("out_eol", 32'(out_eol), 32'(exp_eol));
            check("out_eof", 32'(out_eof), 32'(exp_eof));
        end
    endtask

    task automatic rand_step(input int vpct, input int rpct);
        step($urandom_range(0, 99) < vpct, 1'b0, 12'($urandom), 12'($urandom),
             $urandom_range(0, 99) < rpct, 1'b0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        exp_valid = 1'b0;
        exp_pixel = '0;
        exp_eol   = 1'b0;
        exp_eof   = 1'b0;
        exp_err   = 1'b0;
        pos       = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_pixel", 32'(out_pixel), 32'(0));
        check("rst_out_eol", 32'(out_eol), 32'(0));
        check("rst_out_eof", 32'(out_eof), 32'(0));
        check("rst_sync_err", 32'(sync_err), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_rom_row", 32'(rom_row), 32'(0));
        check("rst_rom_col", 32'(rom_col), 32'(0));
        @(negedge clk);
    endtask

    initial begin
        int guard;

        do_reset();

        // First pixel of a frame, AND mask
        step(1'b1, 1'b1, 12'hFFF, 12'h0F0, 1'b1, 1'b0);
        check("sof_and_pixel", 32'(out_pixel), 32'h0F0);

        // Rest of the frame with random gaps and back-pressure, until wrap
        guard = 0;
        while (pos != 0 && guard < 60000) begin
            rand_step(80, 85);
            guard++;
        end
        check("frame_wrap_pos", 32'(pos), 32'(0));

        // Next accept without sof addresses (0,0) (checked inside step)
        step(1'b1, 1'b0, 12'($urandom), 12'($urandom), 1'b1, 1'b0);

        // Stall: output held for 5 clocks, then released
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 12'($urandom), 12'($urandom), 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, 12'($urandom), 12'($urandom), 1'b1, 1'b0);

        // Advance to row 21, col 88 and inject an unexpected sof
        guard = 0;
        while (pos != 21 * IMG_W + 88 && guard < 20000) begin
            rand_step(85, 90);
            guard++;
        end
        check("reach_21_88", 32'(pos), 32'(21 * IMG_W + 88));
        step(1'b1, 1'b1, 12'($urandom), 12'($urandom), 1'b1, 1'b0);
        check("sync_err_set", 32'(sync_err), 32'(1));
        for (int i = 0; i < 20; i++) rand_step(70, 70);

        // Reset while output is stalled and valid
        step(1'b1, 1'b0, 12'($urandom), 12'($urandom), 1'b1, 1'b0);
        step(1'b1, 1'b0, 12'($urandom), 12'($urandom), 1'b0, 1'b0);
        do_reset();

        // Short random stream after reset, including a clean sof at (0,0)
        step(1'b1, 1'b1, 12'($urandom), 12'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) rand_step(75, 75);

`ifdef MASK_BLEND_EN
        step(1'b1, 1'b0, 12'hF80, 12'h1E4, 1'b1, 1'b1);
        check("blend_8B2", 32'(out_pixel), 32'h8B2);
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 3) != 0, 1'b0, 12'($urandom), 12'($urandom),
                 $urandom_range(0, 3) != 0, 1'($urandom));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
